rgb_led_driver: RTL

Consumer end of the 3-bit colour-code interface driven by the dynamic-LED sequencer. It turns the current colour code into three PWM outputs for an RGB LED, with a global brightness level and optional fading between colours. It sits between the sequencer's `colour` output and the board LED pins.

---
 rtl/rgb_led_pkg.sv | 34 +++
 rtl/pwm_channel.sv | 57 +++++
 rtl/rgb_led_driver.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rgb_led_pkg.sv
// Shared definitions for rgb_led_driver: colour codes, channel bit positions,
// the fade state type and small arithmetic helpers.
// Optional fading is selected with the RGB_LED_FADE_EN macro (see rgb_led_driver).
package rgb_led_pkg;

    // Colour codes as produced by the sequencer; bit map is {blue, green, red}.
    localparam logic [2:0] COL_RED     = 3'd1;
    localparam logic [2:0] COL_GREEN   = 3'd2;
    localparam logic [2:0] COL_YELLOW  = 3'd3;
    localparam logic [2:0] COL_BLUE    = 3'd4;
    localparam logic [2:0] COL_MAGENTA = 3'd5;
    localparam logic [2:0] COL_CYAN    = 3'd6;

    // Position of each channel within a colour code.
    localparam int unsigned R_BIT = 0;
    localparam int unsigned G_BIT = 1;
    localparam int unsigned B_BIT = 2;

    typedef enum logic {
        IDLE,
        FADING
    } fade_state_e;

    // Codes 0 and 7 are never legal colours.
    function automatic logic colour_valid(input logic [2:0] code);
        return code inside {COL_RED, COL_GREEN, COL_YELLOW, COL_BLUE, COL_MAGENTA, COL_CYAN};
    endfunction

    // Distance between two duties without any risk of wrap.
    function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel of rgb_led_driver: a duty register that either jumps to its
// target or moves one STEP toward it, plus the output comparator.
// The owner decides when the duty may change (always on a period boundary),
// which is what keeps the output free of mid-period glitches.
module pwm_channel
    import rgb_led_pkg::*;
#(
    parameter int unsigned PWM_W  = 8,
    parameter int unsigned STEP   = 16,
    parameter bit          DIRECT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] tgt,
    output logic [PWM_W-1:0] duty,
    output logic             led,
    output logic             differ
);

    localparam logic [PWM_W-1:0] STEP_V = PWM_W'(STEP);

    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] stepped;
    logic [PWM_W-1:0] duty_d;

    // Next faded duty: land exactly on the target when within one STEP,
    // otherwise move a full STEP; the distance test precedes the add/subtract
    // so the arithmetic can never wrap.
    always_comb begin
        stepped = duty_q;
        if (abs_diff(32'(duty_q), 32'(tgt)) <= STEP) begin
            stepped = tgt;
        end else if (duty_q < tgt) begin
            stepped = duty_q + STEP_V;
        end else begin
            stepped = duty_q - STEP_V;
        end
    end

    assign duty_d = DIRECT ? tgt : stepped;

    // Duty register, loaded only when the owner signals an update.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
        end else if (upd) begin
            duty_q <= duty_d;
        end
    end

    assign duty   = duty_q;
    assign led    = (cnt < duty_q);
    assign differ = (duty_q != tgt);

endmodule

// File: rtl/rgb_led_driver.sv
// rgb_led_driver: turns the sequencer's 3-bit colour code into three PWM
// outputs with a global brightness level.
// Build option: define RGB_LED_FADE_EN to compile in the fade FSM and its
// period divider; without it every duty loads its target at the next wrap.
module rgb_led_driver
    import rgb_led_pkg::*;
#(
    parameter int unsigned PWM_W    = 8,
    parameter int unsigned FADE_DIV = 4,
    parameter int unsigned STEP     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       colour,
    input  logic [PWM_W-1:0] brightness,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             busy,
    output logic             err_invalid
);

    logic [2:0]       code_q;
    logic             err_q;
    logic [PWM_W-1:0] cnt_q;
    logic             wrap;
    logic             upd;
    logic [PWM_W-1:0] tgt_r, tgt_g, tgt_b;
    logic [PWM_W-1:0] duty_r, duty_g, duty_b;
    logic             diff_r, diff_g, diff_b;

    // Colour capture: valid codes are stored, invalid ones only raise the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= COL_RED;
            err_q  <= 1'b0;
        end else begin
            err_q <= !colour_valid(colour);
            if (colour_valid(colour)) begin
                code_q <= colour;
            end
        end
    end

    assign err_invalid = err_q;

    // Free-running PWM period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PWM_W'(1);
        end
    end

    // High on the last count; the edge that ends this cycle starts a new period.
    assign wrap = (cnt_q == {PWM_W{1'b1}});

    // Channel targets follow the stored code and live brightness immediately.
    always_comb begin
        tgt_r = code_q[R_BIT] ? brightness : '0;
        tgt_g = code_q[G_BIT] ? brightness : '0;
        tgt_b = code_q[B_BIT] ? brightness : '0;
    end

    assign busy = diff_r | diff_g | diff_b;

`ifdef RGB_LED_FADE_EN
    localparam int unsigned      DIV_W       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(FADE_DIV - 1);
    localparam bit               DIRECT_LOAD = 1'b0;

    fade_state_e      state_q;
    logic [DIV_W-1:0] div_q;
    logic             div_done;
    logic             all_near;

    assign div_done = (div_q == DIV_LAST);

    // Every channel within one STEP means the coming step finishes the fade.
    assign all_near = (abs_diff(32'(duty_r), 32'(tgt_r)) <= STEP)
                    && (abs_diff(32'(duty_g), 32'(tgt_g)) <= STEP)
                    && (abs_diff(32'(duty_b), 32'(tgt_b)) <= STEP);

    assign upd = wrap && (state_q == FADING) && div_done;

    // Fade FSM and period divider; both only advance on period boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
        end else if (wrap) begin
            case (state_q)
                IDLE: begin
                    if (busy) begin
                        state_q <= FADING;
                    end
                end
                FADING: begin
                    if (div_done) begin
                        div_q <= '0;
                        if (all_near) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    div_q   <= '0;
                end
            endcase
        end
    end
`else
    localparam bit DIRECT_LOAD = 1'b1;

    assign upd = wrap;
`endif

    pwm_channel #(
        .PWM_W  (PWM_W),
        .STEP   (STEP),
        .DIRECT (DIRECT_LOAD)
    ) u_ch_r (
        .clk    (clk),
        .rst    (rst),
        .upd    (upd),
        .cnt    (cnt_q),
        .tgt    (tgt_r),
        .duty   (duty_r),
        .led    (led_r),
        .differ (diff_r)
    );

    pwm_channel #(
        .PWM_W  (PWM_W),
        .STEP   (STEP),
        .DIRECT (DIRECT_LOAD)
    ) u_ch_g (
        .clk    (clk),
        .rst    (rst),
        .upd    (upd),
        .cnt    (cnt_q),
        .tgt    (tgt_g),
        .duty   (duty_g),
        .led    (led_g),
        .differ (diff_g)
    );

    pwm_channel #(
        .PWM_W  (PWM_W),
        .STEP   (STEP),
        .DIRECT (DIRECT_LOAD)
    ) u_ch_b (
        .clk    (clk),
        .rst    (rst),
        .upd    (upd),
        .cnt    (cnt_q),
        .tgt    (tgt_b),
        .duty   (duty_b),
        .led    (led_b),
        .differ (diff_b)
    );

endmodule
